encoder_8x3: RTL and testbench

Registered 8-to-3 priority encoder that converts an 8-bit request vector into a 3-bit binary index, with a valid flag and an optional multi-hot error flag. It is used wherever a one-hot select or request bus must be compressed to a binary code. The intended stimulus is one-hot; multi-hot inputs resolve deterministically by priority. All outputs are registered on a single clock.

---
 rtl/encoder_8x3_if.sv | 31 +++
 rtl/encoder_8x3.sv | 57 +++++
 tb/tb_encoder_8x3.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/encoder_8x3_if.sv
// Request/encoded-output bundle for encoder_8x3: the master drives en and I,
// and the encoder returns the code, valid and err.
interface encoder_8x3_if;
    logic       en;
    logic [7:0] I;
    logic       Y2;
    logic       Y1;
    logic       Y0;
    logic       valid;
    logic       err;

    modport master (
        output en,
        output I,
        input  Y2,
        input  Y1,
        input  Y0,
        input  valid,
        input  err
    );

    modport slave (
        input  en,
        input  I,
        output Y2,
        output Y1,
        output Y0,
        output valid,
        output err
    );
endinterface

// File: rtl/encoder_8x3.sv
// Registered 8-to-3 priority encoder; the highest set bit of I wins.
// Define ENCODER_8X3_ONEHOT_CHECK_EN to register a multi-hot error flag in err.
module encoder_8x3 (
    input logic           clk,
    input logic           rst,
    encoder_8x3_if.slave  bus
);

    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;

    always_comb begin
        code_d = 3'b000;
        // Ascending scan so the highest set index is the last one assigned.
        for (int n = 0; n < 8; n++) begin
            if (bus.I[n]) code_d = 3'(n);
        end
        valid_d = |bus.I;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= 3'b000;
            valid_q <= 1'b0;
        end else if (bus.en) begin
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Y2    = code_q[2];
    assign bus.Y1    = code_q[1];
    assign bus.Y0    = code_q[0];
    assign bus.valid = valid_q;

`ifdef ENCODER_8X3_ONEHOT_CHECK_EN
    logic err_q, err_d;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    always_comb begin
        err_d = |(bus.I & (bus.I - 8'd1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.en) begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_8x3.sv
// Scoreboard bench for encoder_8x3: directed vectors then random stimulus checked
// against an arithmetic reference model.
module tb_encoder_8x3;

    typedef struct {
        logic [2:0] code;
        logic       valid;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    encoder_8x3_if bus ();

    encoder_8x3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t model;
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 1'b0;

    function automatic exp_t reference(input exp_t prev, input bit r, input bit e,
                                       input logic [7:0] v);
        exp_t   nxt;
        int     idx;
        int     val;
        nxt = prev;
        if (r) begin
            nxt.code  = 3'd0;
            nxt.valid = 1'b0;
            nxt.err   = 1'b0;
        end else if (e) begin
            // floor(log2(v)) gives the index of the highest set bit
            val = int'(v);
            idx = 0;
            while (val > 1) begin
                val = val / 2;
                idx++;
            end
            nxt.code  = 3'(idx);
            nxt.valid = (v != 8'h00);
`ifdef ENCODER_8X3_ONEHOT_CHECK_EN
            nxt.err   = ($countones(v) >= 2);
`else
            nxt.err   = 1'b0;
`endif
        end
        return nxt;
    endfunction

    task automatic step(input bit r, input bit e, input logic [7:0] v);
        @(negedge clk);
        rst    = r;
        bus.en = e;
        bus.I  = v;
        model  = reference(model, r, e, v);
        exp_q.push_back(model);
    endtask

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every edge the encoder presents a fresh register state.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("code",  {bus.Y2, bus.Y1, bus.Y0}, e.code);
                check("valid", {2'b00, bus.valid},       {2'b00, e.valid});
                check("err",   {2'b00, bus.err},         {2'b00, e.err});
            end
        end
    end

    initial begin
        logic [7:0] v;
        int         waited;
        rst    = 1'b1;
        bus.en = 1'b1;
        bus.I  = 8'hFF;
        model.code  = 3'd0;
        model.valid = 1'b0;
        model.err   = 1'b0;

        // Reset with all request lines high
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'hFF);

        // One-hot sweep
        for (int n = 0; n < 8; n++) step(1'b0, 1'b1, 8'(1 << n));

        // Zero and multi-hot
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'b1010_0000);
        step(1'b0, 1'b1, 8'b0010_0100);

        // Enable hold
        step(1'b0, 1'b1, 8'h08);
        for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 8'h80);
        step(1'b0, 1'b1, 8'h80);

        // Reset mid-operation, then release with input held
        step(1'b1, 1'b1, 8'h40);
        step(1'b0, 1'b1, 8'h40);

        // Random mix of one-hot, zero and arbitrary vectors
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       v = 8'(1 << $urandom_range(0, 7));
                1:       v = 8'h00;
                default: v = 8'($urandom);
            endcase
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), v);
        end
        stim_done = 1'b1;

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
